// File: rtl/rka_loader_if.sv
// rtl/rka_loader_if.sv - download channel, sram write port and status bundle for rka_loader
// master = loader side, slave = data_io / sram mux / host side.
interface rka_loader_if;
  logic        dl_active;
  logic        dl_wr;
  logic [7:0]  dl_data;
  logic        mem_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic [15:0] start_addr;
  logic [15:0] end_addr;
  logic        busy;
  logic        done;
  logic        err_len;
  logic        err_cs;
  logic        err_ovr;

  modport master (
    input  dl_active, dl_wr, dl_data, mem_ready,
    output mem_we, mem_addr, mem_data, start_addr, end_addr,
    output busy, done, err_len, err_cs, err_ovr
  );

  modport slave (
    output dl_active, dl_wr, dl_data, mem_ready,
    input  mem_we, mem_addr, mem_data, start_addr, end_addr,
    input  busy, done, err_len, err_cs, err_ovr
  );
endinterface

// File: rtl/rka_loader.sv
// rtl/rka_loader.sv - RKA tape image parser turning the download stream into CPU-address RAM writes
// Optional trailer checksum verification is enabled by defining RKA_CHECKSUM_EN.
module rka_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hE6,
  parameter int         MAX_PEND  = 1
) (
  input logic          clk,
  input logic          reset,
  rka_loader_if.master bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_H0, S_H1, S_H2, S_H3, S_DATA, S_SYNC, S_CS_HI, S_CS_LO, S_DONE, S_ERR
  } state_t;

  state_t              state;
  logic                act_q;
  logic [MAX_PEND-1:0] pend;
  logic [15:0]         ptr;
  logic [15:0]         cnt;
  logic                rise;
  logic                fall;
  logic                in_image;
  logic                can_load;
  logic [15:0]         hdr_end;

  assign rise     = bus.dl_active & ~act_q;
  assign fall     = ~bus.dl_active & act_q;
  assign in_image = (state != S_IDLE) && (state != S_DONE) && (state != S_ERR);
  // The skid slot may be refilled in the same cycle the sram drains it.
  assign can_load = ~pend[0] | bus.mem_ready;
  assign hdr_end  = {bus.end_addr[15:8], bus.dl_data};
  assign bus.mem_we = pend[0];

`ifdef RKA_CHECKSUM_EN
  logic [15:0] cs_acc;
  logic [7:0]  cs_hi;
  logic [8:0]  lo_sum;
  assign lo_sum = {1'b0, cs_acc[7:0]} + {1'b0, bus.dl_data};
`else
  assign bus.err_cs = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      act_q          <= 1'b0;
      pend           <= '0;
      ptr            <= '0;
      cnt            <= '0;
      bus.mem_addr   <= '0;
      bus.mem_data   <= '0;
      bus.start_addr <= '0;
      bus.end_addr   <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err_len    <= 1'b0;
      bus.err_ovr    <= 1'b0;
`ifdef RKA_CHECKSUM_EN
      cs_acc         <= '0;
      cs_hi          <= '0;
      bus.err_cs     <= 1'b0;
`endif
    end else begin
      act_q <= bus.dl_active;
      if (pend[0] && bus.mem_ready) pend <= '0;

      if (rise) begin
        // A new image discards anything still waiting in the write slot.
        state          <= S_H0;
        pend           <= '0;
        bus.busy       <= 1'b1;
        bus.done       <= 1'b0;
        bus.err_len    <= 1'b0;
        bus.err_ovr    <= 1'b0;
        bus.start_addr <= '0;
        bus.end_addr   <= '0;
`ifdef RKA_CHECKSUM_EN
        cs_acc         <= '0;
        bus.err_cs     <= 1'b0;
`endif
      end else if (fall && in_image) begin
        state       <= S_ERR;
        bus.err_len <= 1'b1;
        bus.busy    <= 1'b0;
      end else if (state == S_DONE) begin
        if (!pend[0]) begin
          state    <= S_IDLE;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
        end
      end else if (bus.dl_wr) begin
        case (state)
          S_H0: begin bus.start_addr[15:8] <= bus.dl_data; state <= S_H1; end
          S_H1: begin bus.start_addr[7:0]  <= bus.dl_data; state <= S_H2; end
          S_H2: begin bus.end_addr[15:8]   <= bus.dl_data; state <= S_H3; end
          S_H3: begin
            bus.end_addr[7:0] <= bus.dl_data;
            if (hdr_end < bus.start_addr) begin
              state       <= S_ERR;
              bus.err_len <= 1'b1;
              bus.busy    <= 1'b0;
            end else begin
              ptr   <= bus.start_addr;
              cnt   <= hdr_end - bus.start_addr;
              state <= S_DATA;
            end
          end
          S_DATA: begin
            if (can_load) begin
              pend         <= MAX_PEND'(1);
              bus.mem_addr <= ptr;
              bus.mem_data <= bus.dl_data;
              ptr          <= ptr + 16'd1;
              if (cnt == 16'd0) state <= S_SYNC;
              else              cnt   <= cnt - 16'd1;
`ifdef RKA_CHECKSUM_EN
              // The final data byte only feeds the low byte, without carry into hi.
              if (cnt == 16'd0) cs_acc[7:0] <= lo_sum[7:0];
              else cs_acc <= {cs_acc[15:8] + bus.dl_data + {7'd0, lo_sum[8]}, lo_sum[7:0]};
`endif
            end else begin
              bus.err_ovr <= 1'b1;
            end
          end
          S_SYNC: if (bus.dl_data == SYNC_BYTE) state <= S_CS_HI;
          S_CS_HI: begin
`ifdef RKA_CHECKSUM_EN
            cs_hi <= bus.dl_data;
`endif
            state <= S_CS_LO;
          end
          S_CS_LO: begin
`ifdef RKA_CHECKSUM_EN
            bus.err_cs <= ({cs_hi, bus.dl_data} != cs_acc);
`endif
            state <= S_DONE;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
